// File: rtl/axis_frame_packer.sv
// First-word-fall-through pixel FIFO that packs a stream into AXI4-Stream frames with per-frame TLAST.
// Optional FRAME_PACKER_TUSER_EN adds an m_tuser start-of-frame output.
module axis_frame_packer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic [DATA_W-1:0]          s_tdata,
    input  logic                       s_tvalid,
    output logic [DATA_W-1:0]          m_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic                       m_tlast,
`ifdef FRAME_PACKER_TUSER_EN
    output logic                       m_tuser,
`endif
    output logic                       frame_done,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic              full;
    logic              rd_hs;
    logic              wr_en;
    logic              rd_en;
    logic              drop;
    logic              col_end;
    logic              row_end;

    assign full     = (level == FULL_LVL);
    assign m_tvalid = (level != '0);
    assign m_tdata  = mem[rd_ptr];
    assign rd_hs    = m_tvalid && m_tready;
    // A read in the same cycle frees a slot, so a write into a full FIFO is still accepted.
    assign wr_en    = s_tvalid && !clr && (!full || rd_hs);
    assign rd_en    = rd_hs && !clr;
    assign drop     = s_tvalid && !clr && full && !rd_hs;

    assign col_end  = (col == COL_MAX);
    assign row_end  = (row == ROW_MAX);
    assign m_tlast  = m_tvalid && col_end && row_end;
`ifdef FRAME_PACKER_TUSER_EN
    assign m_tuser  = m_tvalid && (col == '0) && (row == '0);
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + LW'(wr_en) - LW'(rd_en);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else if (clr) begin
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= rd_hs && col_end && row_end;
            if (drop) begin
                overflow <= 1'b1;
            end
            if (rd_hs) begin
                if (col_end) begin
                    col <= '0;
                    row <= row_end ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_frame_packer.sv
// Randomized bench for axis_frame_packer (IMG_W=4, IMG_H=2, DEPTH=16) against a queue-based frame model.
module tb_axis_frame_packer;

    localparam int DW = 32;
    localparam int DEPTH = 16;
    localparam int FRAME = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic          frame_done;
    logic          overflow;
    logic [4:0]    level;
`ifdef FRAME_PACKER_TUSER_EN
    logic          m_tuser;
`endif

    int errors = 0;
    int checks = 0;

    axis_frame_packer #(.DATA_W(DW), .DEPTH(DEPTH), .IMG_W(4), .IMG_H(2)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
`ifdef FRAME_PACKER_TUSER_EN
        .m_tuser(m_tuser),
`endif
        .frame_done(frame_done), .overflow(overflow), .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of stored words, a handshake position inside the frame, sticky drop flag.
    logic [DW-1:0] q[$];
    int  hs_pos = 0;
    bit  ovf_m = 0;
    bit  fd_m = 0;

    always @(negedge clk) begin
        bit vld, rd, wr;
        if (rst) begin
            q.delete();
            hs_pos = 0;
            ovf_m = 0;
            fd_m = 0;
            check("rst_tvalid", DW'(m_tvalid), 0);
            check("rst_level", DW'(level), 0);
            check("rst_overflow", DW'(overflow), 0);
            check("rst_frame_done", DW'(frame_done), 0);
            check("rst_tlast", DW'(m_tlast), 0);
        end else begin
            vld = (q.size() != 0);
            check("tvalid", DW'(m_tvalid), DW'(vld));
            check("level", DW'(level), DW'(q.size()));
            check("overflow", DW'(overflow), DW'(ovf_m));
            check("frame_done", DW'(frame_done), DW'(fd_m));
            check("tlast", DW'(m_tlast), DW'(vld && hs_pos == FRAME - 1));
`ifdef FRAME_PACKER_TUSER_EN
            check("tuser", DW'(m_tuser), DW'(vld && hs_pos == 0));
`endif
            if (vld) check("tdata", m_tdata, q[0]);
            if (clr) begin
                q.delete();
                hs_pos = 0;
                ovf_m = 0;
                fd_m = 0;
            end else begin
                rd = vld && m_tready;
                fd_m = rd && (hs_pos == FRAME - 1);
                wr = s_tvalid && (q.size() < DEPTH || rd);
                if (s_tvalid && !wr) ovf_m = 1;
                if (rd) begin
                    void'(q.pop_front());
                    hs_pos = (hs_pos + 1) % FRAME;
                end
                if (wr) q.push_back(s_tdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        s_tvalid = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        step();
        step();
        check("lit_reset_tvalid", DW'(m_tvalid), 0);
        check("lit_reset_level", DW'(level), 0);
        rst = 1'b0;
        m_tready = 1'b1;

        // Back-to-back frame: each word visible one cycle after input, tlast on word 8 only.
        for (int i = 1; i <= 8; i++) begin
            s_tvalid = 1'b1;
            s_tdata = DW'(i);
            step();
            check("lit_pass_data", m_tdata, DW'(i));
            check("lit_pass_tlast", DW'(m_tlast), DW'(i == 8));
        end
        s_tvalid = 1'b0;
        step();
        check("lit_frame_done", DW'(frame_done), 1);
        step();
        check("lit_frame_done_once", DW'(frame_done), 0);

        for (int c = 0; c < 400; c++) begin
            s_tvalid = ($urandom_range(0, 3) != 0);
            s_tdata = $urandom;
            m_tready = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 80) == 0);
            step();
        end
        clr = 1'b0;

        // Fill under backpressure, then a simultaneous read/write while full, then a drop.
        pulse_clr();
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_tvalid = 1'b1;
            s_tdata = DW'(101 + i);
            step();
        end
        s_tvalid = 1'b0;
        check("lit_full_level", DW'(level), 16);
        check("lit_full_overflow", DW'(overflow), 0);
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        s_tdata = DW'(200);
        step();
        m_tready = 1'b0;
        s_tvalid = 1'b0;
        check("lit_simul_level", DW'(level), 16);
        check("lit_simul_overflow", DW'(overflow), 0);
        check("lit_simul_head", m_tdata, DW'(102));
        s_tvalid = 1'b1;
        s_tdata = DW'(201);
        step();
        s_tvalid = 1'b0;
        check("lit_drop_overflow", DW'(overflow), 1);
        check("lit_drop_level", DW'(level), 16);
        m_tready = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("lit_drain_level", DW'(level), 0);

        // clr after three output words, with a word pending and one arriving.
        for (int i = 1; i <= 4; i++) begin
            s_tvalid = 1'b1;
            s_tdata = DW'(300 + i);
            step();
        end
        s_tdata = DW'(399);
        clr = 1'b1;
        step();
        clr = 1'b0;
        s_tvalid = 1'b0;
        check("lit_clr_level", DW'(level), 0);
        check("lit_clr_overflow", DW'(overflow), 0);
        for (int i = 1; i <= 8; i++) begin
            s_tvalid = 1'b1;
            s_tdata = DW'(400 + i);
            step();
            check("lit_clr_tlast", DW'(m_tlast), DW'(i == 8));
        end
        s_tvalid = 1'b0;
        step();

        // Asynchronous reset between edges while data is waiting.
        m_tready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_tvalid = 1'b1;
            s_tdata = DW'(500 + i);
            step();
        end
        s_tvalid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("lit_async_tvalid", DW'(m_tvalid), 0);
        check("lit_async_level", DW'(level), 0);
        step();
        rst = 1'b0;
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        s_tdata = DW'(55);
        step();
        s_tvalid = 1'b0;
        check("lit_after_rst_data", m_tdata, DW'(55));
`ifdef FRAME_PACKER_TUSER_EN
        check("lit_after_rst_tuser", DW'(m_tuser), 1);
`endif
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_frame_packer.md
AXIS_FRAME_PACKER -- requirements
Module: axis_frame_packer

Interface
REQ-001 Parameter DATA_W, default 32: stream word width; the pixel is in bits [23:0] as {R,G,B}.
REQ-002 Parameter DEPTH, default 16: FIFO depth in words; it SHALL be a power of two and at least 4.
REQ-003 Parameter IMG_W, default 512: pixels per line.
REQ-004 Parameter IMG_H, default 512: lines per frame.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-006 clk  in  1  single clock; all state changes on the rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 clr  in  1  synchronous clear of the FIFO, counters and flags.
REQ-009 s_tdata  in  DATA_W  processed pixel from the haze-removal stage.
REQ-010 s_tvalid  in  1  input word valid; there is no ready, so the source cannot be stalled.
REQ-011 m_tdata  out  DATA_W  output word to the DMA S2MM channel.
REQ-012 m_tvalid  out  1  output word valid.
REQ-013 m_tready  in  1  downstream ready.
REQ-014 m_tlast  out  1  marks the last pixel of a frame.
REQ-015 frame_done  out  1  one-cycle pulse when a frame has been fully transferred.
REQ-016 overflow  out  1  sticky flag: an input word was dropped.
REQ-017 level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-018 The FIFO SHALL be first-word-fall-through: m_tdata = mem[rd_ptr] and m_tvalid = (level != 0).
REQ-019 Write: s_tvalid with level < DEPTH stores the word; write-to-m_tvalid latency is 1 cycle.
REQ-020 Read: a handshake is m_tvalid && m_tready; each handshake advances rd_ptr by one.
REQ-021 Simultaneous write and read: level is unchanged; this holds when full (the write is accepted) and when level=1.
REQ-022 Drop: s_tvalid with level=DEPTH and no read in that cycle SHALL drop the word and set overflow until rst or clr.
REQ-023 Pointers SHALL wrap modulo DEPTH.
REQ-024 m_tdata and m_tvalid SHALL hold stable while m_tvalid && !m_tready.
REQ-025 Counters col (0..IMG_W-1) and row (0..IMG_H-1) SHALL advance on output handshakes only.
  - col wraps to 0 and increments row.
  - At col=IMG_W-1 and row=IMG_H-1 both counters wrap to 0.
REQ-026 m_tlast = m_tvalid && (col==IMG_W-1) && (row==IMG_H-1), combinational from the counters.
REQ-027 frame_done SHALL pulse high for exactly one cycle, registered, in the cycle after the m_tlast handshake.
REQ-028 clr SHALL empty the FIFO, zero col, row and level, clear overflow, and drop any s_tvalid word in the same cycle.
  - clr has priority over every other event.
REQ-029 Dropped words SHALL NOT advance the counters; the frame stays IMG_W*IMG_H output words long.

Reset
REQ-030 On rst, without waiting for clk, the block SHALL force:
  - m_tvalid=0, m_tlast=0, frame_done=0, overflow=0, level=0;
  - pointers, col and row to 0.
  - m_tdata is don't-care.
REQ-031 Reset mid-frame SHALL discard the partial frame; the first word after reset is col 0, row 0.

Configuration
REQ-032 The macro FRAME_PACKER_TUSER_EN SHALL control a start-of-frame output.
  - Defined: adds output m_tuser (1 bit) = m_tvalid && col==0 && row==0 (AXI4-Stream video SOF).
  - Undefined: the port is absent and there is no other change in behaviour.

Verification
REQ-033 Reset-release test: IMG_W=4, IMG_H=2, m_tready=1, 8 consecutive s_tvalid words 1..8.
  - Output words 1..8 appear, each one cycle after its input.
  - m_tlast is high only on word 8.
  - frame_done pulses in the cycle after word 8.
REQ-034 Backpressure test: m_tready=0, write 16 words (DEPTH=16).
  - level=16, overflow=0.
  - Write a 17th word: overflow=1 and level stays 16.
  - Release m_tready: words 1..16 come out in order.
REQ-035 Full-simultaneous test: level=16, m_tready=1 and s_tvalid in the same cycle.
  - level stays 16, overflow stays 0, and the new word appears 16 handshakes later.
REQ-036 clr mid-frame test: pulse clr after 3 output words.
  - level=0, overflow=0.
  - The next frame's m_tlast falls on its 8th handshake.
REQ-037 Asynchronous reset test: assert rst between clock edges while m_tvalid=1.
  - m_tvalid falls immediately.
  - With FRAME_PACKER_TUSER_EN defined, m_tuser=1 on the first word after release.
